// File: rtl/toy_rename_map_table_if.sv
// Rename-stage bus: decode group in, regfile pre-allocation, renamed group out,
// and commit/release traffic toward the regfile. Master drives, slave is the rename table.
interface toy_rename_map_table_if #(
    parameter int unsigned DECODE_NUM   = 4,
    parameter int unsigned COMMIT_NUM   = 4,
    parameter int unsigned ARCH_REG_NUM = 32,
    parameter int unsigned PHY_ID_W     = 7
);
    localparam int unsigned ARCH_W = $clog2(ARCH_REG_NUM);

    logic [DECODE_NUM-1:0]                in_vld;
    logic                                 in_rdy;
    logic [DECODE_NUM-1:0][ARCH_W-1:0]    in_rs1;
    logic [DECODE_NUM-1:0][ARCH_W-1:0]    in_rs2;
    logic [DECODE_NUM-1:0][ARCH_W-1:0]    in_rs3;
    logic [DECODE_NUM-1:0][ARCH_W-1:0]    in_rd;
    logic [DECODE_NUM-1:0]                in_rd_wr;

    logic [DECODE_NUM-1:0]                pre_alloc_vld;
    logic [DECODE_NUM-1:0][PHY_ID_W-1:0]  pre_alloc_id;
    logic [DECODE_NUM-1:0]                pre_alloc_rdy;
    logic [DECODE_NUM-1:0]                pre_alloc_zero;

    logic [DECODE_NUM-1:0]                out_vld;
    logic                                 out_rdy;
    logic [DECODE_NUM-1:0][PHY_ID_W-1:0]  out_phy_rs1;
    logic [DECODE_NUM-1:0][PHY_ID_W-1:0]  out_phy_rs2;
    logic [DECODE_NUM-1:0][PHY_ID_W-1:0]  out_phy_rs3;
    logic [DECODE_NUM-1:0][PHY_ID_W-1:0]  out_phy_rd;
    logic [DECODE_NUM-1:0][PHY_ID_W-1:0]  out_old_phy_rd;

    logic [COMMIT_NUM-1:0]                commit_en;
    logic [COMMIT_NUM-1:0][ARCH_W-1:0]    commit_rd;
    logic [COMMIT_NUM-1:0][PHY_ID_W-1:0]  commit_phy;
    logic [COMMIT_NUM-1:0]                rel_en;
    logic [COMMIT_NUM-1:0][PHY_ID_W-1:0]  rel_index;
    logic [COMMIT_NUM-1:0][PHY_ID_W-1:0]  backup_index;

    logic                                 cancel_en;

    modport master (
        output in_vld, in_rs1, in_rs2, in_rs3, in_rd, in_rd_wr,
        output pre_alloc_vld, pre_alloc_id, out_rdy,
        output commit_en, commit_rd, commit_phy, cancel_en,
        input  in_rdy, pre_alloc_rdy, pre_alloc_zero,
        input  out_vld, out_phy_rs1, out_phy_rs2, out_phy_rs3, out_phy_rd, out_old_phy_rd,
        input  rel_en, rel_index, backup_index
    );

    modport slave (
        input  in_vld, in_rs1, in_rs2, in_rs3, in_rd, in_rd_wr,
        input  pre_alloc_vld, pre_alloc_id, out_rdy,
        input  commit_en, commit_rd, commit_phy, cancel_en,
        output in_rdy, pre_alloc_rdy, pre_alloc_zero,
        output out_vld, out_phy_rs1, out_phy_rs2, out_phy_rs3, out_phy_rd, out_old_phy_rd,
        output rel_en, rel_index, backup_index
    );
endinterface

// File: rtl/toy_rename_map_table.sv
// Register rename map table with speculative and architectural tables.
// Optional consistency checker enabled by defining TOY_RAT_CHECK_EN (adds err_flag).
module toy_rename_map_table #(
    parameter int unsigned DECODE_NUM   = 4,
    parameter int unsigned COMMIT_NUM   = 4,
    parameter int unsigned ARCH_REG_NUM = 32,
    parameter int unsigned PHY_ID_W     = 7,
    parameter int unsigned MODE         = 0
) (
    input  logic clk,
    input  logic rst_n,
    toy_rename_map_table_if.slave bus
`ifdef TOY_RAT_CHECK_EN
    ,
    output logic err_flag
`endif
);
    localparam int unsigned ARCH_W = $clog2(ARCH_REG_NUM);

    typedef logic [PHY_ID_W-1:0] phy_t;

    phy_t [ARCH_REG_NUM-1:0] spec_tbl;
    phy_t [ARCH_REG_NUM-1:0] arch_tbl;
    phy_t [ARCH_REG_NUM-1:0] spec_upd;
    phy_t [ARCH_REG_NUM-1:0] spec_nxt;
    phy_t [ARCH_REG_NUM-1:0] arch_nxt;

    logic [DECODE_NUM-1:0] need;
    logic                  alloc_ok;
    logic                  fire;

    phy_t [DECODE_NUM-1:0] rs1_map;
    phy_t [DECODE_NUM-1:0] rs2_map;
    phy_t [DECODE_NUM-1:0] rs3_map;
    phy_t [DECODE_NUM-1:0] rd_map;
    phy_t [DECODE_NUM-1:0] old_map;

    logic [COMMIT_NUM-1:0] rel_ok;
    phy_t [COMMIT_NUM-1:0] rel_map;

    // Lanes that really allocate: x0 in INT mode is never renamed
    always_comb begin
        need     = '0;
        alloc_ok = 1'b1;
        for (int unsigned i = 0; i < DECODE_NUM; i++) begin
            need[i] = bus.in_vld[i] & bus.in_rd_wr[i] &
                      !((MODE == 0) && (bus.in_rd[i] == '0));
            if (need[i] && !bus.pre_alloc_vld[i]) alloc_ok = 1'b0;
        end
    end

    // Whole group moves or nothing does
    assign fire = (|bus.in_vld) & !bus.cancel_en &
                  (!(|bus.out_vld) | bus.out_rdy) & alloc_ok;

    assign bus.in_rdy = fire;

    always_comb begin
        bus.pre_alloc_rdy  = '0;
        bus.pre_alloc_zero = '0;
        for (int unsigned i = 0; i < DECODE_NUM; i++) begin
            bus.pre_alloc_rdy[i]  = fire & need[i];
            bus.pre_alloc_zero[i] = fire & bus.in_vld[i] & !need[i];
        end
    end

    // Source/old-rd lookup with intra-group bypass; later older lane overrides earlier
    always_comb begin
        rs1_map = '0;
        rs2_map = '0;
        rs3_map = '0;
        rd_map  = '0;
        old_map = '0;
        for (int unsigned i = 0; i < DECODE_NUM; i++) begin
            rs1_map[i] = spec_tbl[bus.in_rs1[i]];
            rs2_map[i] = spec_tbl[bus.in_rs2[i]];
            rs3_map[i] = spec_tbl[bus.in_rs3[i]];
            old_map[i] = spec_tbl[bus.in_rd[i]];
            for (int unsigned j = 0; j < DECODE_NUM; j++) begin
                if (j < i && need[j]) begin
                    if (bus.in_rd[j] == bus.in_rs1[i]) rs1_map[i] = bus.pre_alloc_id[j];
                    if (bus.in_rd[j] == bus.in_rs2[i]) rs2_map[i] = bus.pre_alloc_id[j];
                    if (bus.in_rd[j] == bus.in_rs3[i]) rs3_map[i] = bus.pre_alloc_id[j];
                    if (bus.in_rd[j] == bus.in_rd[i])  old_map[i] = bus.pre_alloc_id[j];
                end
            end
            if (MODE == 0) begin
                if (bus.in_rs1[i] == '0) rs1_map[i] = '0;
                if (bus.in_rs2[i] == '0) rs2_map[i] = '0;
                if (bus.in_rs3[i] == '0) rs3_map[i] = '0;
                if (bus.in_rd[i] == '0)  old_map[i] = '0;
            end
            rd_map[i] = need[i] ? bus.pre_alloc_id[i] : '0;
        end
    end

    // Speculative table after this group's writes; youngest lane wins
    always_comb begin
        spec_upd = spec_tbl;
        for (int unsigned i = 0; i < DECODE_NUM; i++) begin
            if (need[i]) spec_upd[bus.in_rd[i]] = bus.pre_alloc_id[i];
        end
    end

    // Commit: release index is read before each lane's own write, giving the older-lane bypass
    always_comb begin
        arch_nxt = arch_tbl;
        rel_ok   = '0;
        rel_map  = '0;
        for (int unsigned k = 0; k < COMMIT_NUM; k++) begin
            rel_ok[k]  = bus.commit_en[k] & !((MODE == 0) && (bus.commit_rd[k] == '0));
            rel_map[k] = arch_nxt[bus.commit_rd[k]];
            if (rel_ok[k]) arch_nxt[bus.commit_rd[k]] = bus.commit_phy[k];
        end
    end

    assign bus.rel_en       = rel_ok;
    assign bus.rel_index    = rel_map;
    assign bus.backup_index = bus.commit_phy;

    always_comb begin
        spec_nxt = spec_tbl;
        if (bus.cancel_en) spec_nxt = arch_nxt;
        else if (fire)     spec_nxt = spec_upd;
    end

    // Tables reset to the identity mapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < ARCH_REG_NUM; r++) begin
                spec_tbl[r] <= PHY_ID_W'(r);
                arch_tbl[r] <= PHY_ID_W'(r);
            end
        end else begin
            spec_tbl <= spec_nxt;
            arch_tbl <= arch_nxt;
        end
    end

    // Renamed output group register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_vld        <= '0;
            bus.out_phy_rs1    <= '0;
            bus.out_phy_rs2    <= '0;
            bus.out_phy_rs3    <= '0;
            bus.out_phy_rd     <= '0;
            bus.out_old_phy_rd <= '0;
        end else if (fire) begin
            bus.out_vld        <= bus.in_vld;
            bus.out_phy_rs1    <= rs1_map;
            bus.out_phy_rs2    <= rs2_map;
            bus.out_phy_rs3    <= rs3_map;
            bus.out_phy_rd     <= rd_map;
            bus.out_old_phy_rd <= old_map;
        end else if (bus.out_rdy || bus.cancel_en) begin
            bus.out_vld <= '0;
        end
    end

`ifdef TOY_RAT_CHECK_EN
    logic err_set;

    // Zero ID handed out in INT mode, or a release that frees the phy being backed up
    always_comb begin
        err_set = 1'b0;
        for (int unsigned i = 0; i < DECODE_NUM; i++) begin
            if ((MODE == 0) && fire && need[i] && (bus.pre_alloc_id[i] == '0)) err_set = 1'b1;
        end
        for (int unsigned k = 0; k < COMMIT_NUM; k++) begin
            if (rel_ok[k] && (rel_map[k] == bus.commit_phy[k])) err_set = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       err_flag <= 1'b0;
        else if (err_set) err_flag <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_toy_rename_map_table.sv
// Directed test of toy_rename_map_table (MODE 0, 4 decode / 4 commit lanes).
module tb_toy_rename_map_table;
    logic clk;
    logic rst_n;
`ifdef TOY_RAT_CHECK_EN
    logic err_flag;
`endif

    int checks = 0;
    int errors = 0;

    toy_rename_map_table_if #(.DECODE_NUM(4), .COMMIT_NUM(4), .ARCH_REG_NUM(32), .PHY_ID_W(7)) bus ();

    toy_rename_map_table #(
        .DECODE_NUM(4), .COMMIT_NUM(4), .ARCH_REG_NUM(32), .PHY_ID_W(7), .MODE(0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
`ifdef TOY_RAT_CHECK_EN
        ,
        .err_flag(err_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_vld        = '0;
        bus.in_rs1        = '0;
        bus.in_rs2        = '0;
        bus.in_rs3        = '0;
        bus.in_rd         = '0;
        bus.in_rd_wr      = '0;
        bus.pre_alloc_vld = '0;
        bus.pre_alloc_id  = '0;
        bus.commit_en     = '0;
        bus.commit_rd     = '0;
        bus.commit_phy    = '0;
        bus.cancel_en     = 1'b0;
    endtask

    task automatic lane(input int unsigned i, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rs3, input logic [4:0] rd, input logic wr,
                        input logic [6:0] id);
        bus.in_vld[i]        = 1'b1;
        bus.in_rs1[i]        = rs1;
        bus.in_rs2[i]        = rs2;
        bus.in_rs3[i]        = rs3;
        bus.in_rd[i]         = rd;
        bus.in_rd_wr[i]      = wr;
        bus.pre_alloc_vld[i] = wr;
        bus.pre_alloc_id[i]  = id;
    endtask

    task automatic commit(input int unsigned k, input logic [4:0] rd, input logic [6:0] phy);
        bus.commit_en[k]  = 1'b1;
        bus.commit_rd[k]  = rd;
        bus.commit_phy[k] = phy;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.out_rdy = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("reset_out_vld", 32'(bus.out_vld), 32'd0);
        check("reset_out_rd0", 32'(bus.out_phy_rd[0]), 32'd0);
        check("reset_in_rdy", 32'(bus.in_rdy), 32'd0);
        check("reset_rel_en", 32'(bus.rel_en), 32'd0);

        // Single lane rename rd=5 -> 40
        lane(0, 5'd5, 5'd6, 5'd0, 5'd5, 1'b1, 7'd40);
        #1;
        check("t1_in_rdy", 32'(bus.in_rdy), 32'd1);
        check("t1_pa_rdy", 32'(bus.pre_alloc_rdy), 32'b0001);
        check("t1_pa_zero", 32'(bus.pre_alloc_zero), 32'b0000);
        step();
        check("t1_out_vld", 32'(bus.out_vld), 32'b0001);
        check("t1_rs1", 32'(bus.out_phy_rs1[0]), 32'd5);
        check("t1_rs2", 32'(bus.out_phy_rs2[0]), 32'd6);
        check("t1_rd", 32'(bus.out_phy_rd[0]), 32'd40);
        check("t1_old", 32'(bus.out_old_phy_rd[0]), 32'd5);
        idle();
        lane(0, 5'd5, 5'd0, 5'd0, 5'd0, 1'b0, 7'd0);
        #1;
        check("t1_probe_zero", 32'(bus.pre_alloc_zero), 32'b0001);
        step();
        check("t1_spec5", 32'(bus.out_phy_rs1[0]), 32'd40);
        check("t1_probe_rd", 32'(bus.out_phy_rd[0]), 32'd0);

        // Intra-group bypass
        idle();
        lane(0, 5'd0, 5'd0, 5'd0, 5'd3, 1'b1, 7'd33);
        lane(1, 5'd3, 5'd0, 5'd0, 5'd3, 1'b1, 7'd34);
        step();
        check("t2_rs1_l1", 32'(bus.out_phy_rs1[1]), 32'd33);
        check("t2_old_l1", 32'(bus.out_old_phy_rd[1]), 32'd33);
        check("t2_rd_l1", 32'(bus.out_phy_rd[1]), 32'd34);
        check("t2_old_l0", 32'(bus.out_old_phy_rd[0]), 32'd3);
        idle();
        lane(0, 5'd3, 5'd0, 5'd0, 5'd0, 1'b0, 7'd0);
        step();
        check("t2_spec3", 32'(bus.out_phy_rs1[0]), 32'd34);

        // x0 destination allocates nothing
        idle();
        lane(0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 7'd77);
        #1;
        check("t3_pa_zero", 32'(bus.pre_alloc_zero), 32'b0001);
        check("t3_pa_rdy", 32'(bus.pre_alloc_rdy), 32'b0000);
        step();
        check("t3_rd", 32'(bus.out_phy_rd[0]), 32'd0);
        check("t3_old", 32'(bus.out_old_phy_rd[0]), 32'd0);

        // Lane 1 missing allocation stalls the whole group
        idle();
        lane(0, 5'd0, 5'd0, 5'd0, 5'd10, 1'b1, 7'd41);
        lane(1, 5'd0, 5'd0, 5'd0, 5'd11, 1'b1, 7'd42);
        bus.pre_alloc_vld[1] = 1'b0;
        #1;
        check("t4_in_rdy", 32'(bus.in_rdy), 32'd0);
        check("t4_pa_rdy", 32'(bus.pre_alloc_rdy), 32'b0000);
        step();
        check("t4_no_out", 32'(bus.out_vld), 32'b0000);
        bus.pre_alloc_vld[1] = 1'b1;
        #1;
        check("t4_in_rdy_go", 32'(bus.in_rdy), 32'd1);
        step();
        check("t4_out_vld", 32'(bus.out_vld), 32'b0011);
        check("t4_rd_l1", 32'(bus.out_phy_rd[1]), 32'd42);

        // Backpressure holds the output group
        idle();
        lane(0, 5'd0, 5'd0, 5'd0, 5'd12, 1'b1, 7'd43);
        bus.out_rdy = 1'b0;
        #1;
        check("t5_in_rdy", 32'(bus.in_rdy), 32'd0);
        step();
        check("t5_hold_vld", 32'(bus.out_vld), 32'b0011);
        check("t5_hold_rd", 32'(bus.out_phy_rd[1]), 32'd42);
        bus.out_rdy = 1'b1;
        idle();
        step();
        check("t5_drain", 32'(bus.out_vld), 32'b0000);

        // Two commits to the same rd in one cycle
        idle();
        commit(0, 5'd7, 7'd50);
        commit(1, 5'd7, 7'd51);
        #1;
        check("t6_rel_en", 32'(bus.rel_en), 32'b0011);
        check("t6_rel0", 32'(bus.rel_index[0]), 32'd7);
        check("t6_rel1", 32'(bus.rel_index[1]), 32'd50);
        check("t6_bk0", 32'(bus.backup_index[0]), 32'd50);
        check("t6_bk1", 32'(bus.backup_index[1]), 32'd51);
        step();
        idle();
        commit(0, 5'd7, 7'd52);
        #1;
        check("t6_arch7", 32'(bus.rel_index[0]), 32'd51);
        step();
        idle();
        commit(0, 5'd0, 7'd53);
        #1;
        check("t6_x0_rel_en", 32'(bus.rel_en), 32'b0000);
        step();

        // Rename rd=9, then cancel alongside a commit of rd=9
        idle();
        lane(0, 5'd0, 5'd0, 5'd0, 5'd9, 1'b1, 7'd60);
        step();
        check("t7_rd", 32'(bus.out_phy_rd[0]), 32'd60);
        idle();
        lane(0, 5'd9, 5'd0, 5'd0, 5'd13, 1'b1, 7'd61);
        commit(0, 5'd9, 7'd45);
        bus.cancel_en = 1'b1;
        #1;
        check("t7_cancel_rdy", 32'(bus.in_rdy), 32'd0);
        check("t7_cancel_pa", 32'(bus.pre_alloc_rdy), 32'b0000);
        check("t7_rel9", 32'(bus.rel_index[0]), 32'd9);
        step();
        check("t7_out_vld", 32'(bus.out_vld), 32'b0000);
        idle();
        lane(0, 5'd9, 5'd5, 5'd7, 5'd0, 1'b0, 7'd0);
        lane(1, 5'd3, 5'd0, 5'd0, 5'd0, 1'b0, 7'd0);
        step();
        check("t7_spec9", 32'(bus.out_phy_rs1[0]), 32'd45);
        check("t7_spec5", 32'(bus.out_phy_rs2[0]), 32'd5);
        check("t7_spec7", 32'(bus.out_phy_rs3[0]), 32'd52);
        check("t7_spec3", 32'(bus.out_phy_rs1[1]), 32'd3);

        // Asynchronous reset mid-operation
        idle();
        lane(0, 5'd0, 5'd0, 5'd0, 5'd9, 1'b1, 7'd70);
        step();
        check("t8_pre_vld", 32'(bus.out_vld), 32'b0001);
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("t8_rst_vld", 32'(bus.out_vld), 32'b0000);
        check("t8_rst_rd", 32'(bus.out_phy_rd[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lane(0, 5'd9, 5'd0, 5'd0, 5'd0, 1'b0, 7'd0);
        step();
        check("t8_spec9", 32'(bus.out_phy_rs1[0]), 32'd9);
`ifdef TOY_RAT_CHECK_EN
        check("t8_err_flag", 32'(err_flag), 32'd0);
`endif
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
